// File: rtl/pipeline_fetch_queue.sv
// Fetch stage with PC, 1-cycle imem requests, DEPTH-entry instruction queue and redirects.
// Optional perf counters are enabled with `define FETCH_PERF_EN.
module pipeline_fetch_queue #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [31:0]       HALT_MASK  = 32'h0000_0FFF,
  parameter logic [31:0]       HALT_VALUE = 32'h0000_0300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       instruction_out,
  output logic [ADDR_W-1:0] pc_plus4_out,
  input  logic              zflag,
  input  logic              nzflag,
  input  logic              beqz,
  input  logic              bnez,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] pc_plus4_id,
  input  logic [ADDR_W-1:0] extended_imm,
  input  logic [25:0]       value,
  input  logic [ADDR_W-1:0] register_s1,
  input  logic              stall,
  output logic              branch_out,
  output logic              end_program,
  output logic [ADDR_W-1:0] current_address
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_full
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       instr_d [DEPTH];
  logic [ADDR_W-1:0] pcp4_q [DEPTH];
  logic [ADDR_W-1:0] pcp4_d [DEPTH];

  logic              br_taken, redirect, flush;
  logic              resp_ok, halt_hit, enq, deq, room;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] target;

  assign br_taken = ((zflag & beqz) | (nzflag & bnez)) & ~stall;
  assign redirect = (state_q != S_IDLE) & (jump_reg | jump | br_taken);
  assign flush    = start | redirect;
  assign resp_ok  = inflight_q & ~flush;
  assign halt_hit = resp_ok & ((imem_rdata & HALT_MASK) == HALT_VALUE);
  assign enq      = resp_ok;
  assign if_valid = (count_q != '0);
  assign deq      = if_valid & id_ready;
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign room     = occ < (CW+1)'(DEPTH);

  // Hold off the fetch in the cycle a halt word returns so nothing trails it.
  assign imem_req = (state_q == S_RUN) & room & ~flush & ~halt_hit;

  assign imem_addr       = pc_q;
  assign current_address = pc_q;
  assign instruction_out = instr_q[head_q];
  assign pc_plus4_out    = pcp4_q[head_q];
  assign branch_out      = br_taken & (state_q == S_RUN);
  assign end_program     = (state_q == S_HALT);

  always_comb begin
    target = pc_plus4_id + extended_imm;
    if (jump_reg)  target = register_s1;
    else if (jump) target = pc_plus4_id + {{(ADDR_W-26){value[25]}}, value};
  end

  always_comb begin
    state_d = state_q;
    if (flush)                               state_d = S_RUN;
    else if (halt_hit && state_q == S_RUN)   state_d = S_HALT;
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = imem_req;
    raddr_d    = raddr_q;
    if (start)         pc_d = start_address;
    else if (redirect) pc_d = target;
    else if (imem_req) pc_d = pc_q + FOUR;
    if (imem_req) raddr_d = pc_q;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        instr_d[tail_q] = imem_rdata;
        pcp4_d[tail_q]  = raddr_q + FOUR;
        tail_d          = tail_q + PW'(1);
      end
      if (deq) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_ADDR;
      inflight_q <= 1'b0;
      raddr_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pcp4_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      raddr_q    <= raddr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pcp4_q     <= pcp4_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;
  logic [31:0] full_q, full_d;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    fetched_d = fetched_q;
    flushed_d = flushed_q;
    full_d    = full_q;
    if (start) begin
      fetched_d = '0;
      flushed_d = '0;
      full_d    = '0;
    end else begin
      if (enq)      fetched_d = sat_add(fetched_q, 32'd1);
      if (redirect) flushed_d = sat_add(flushed_q, 32'(occ));
      if (state_q == S_RUN && !room) full_d = sat_add(full_q, 32'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
      full_q    <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
      full_q    <= full_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_full    = full_q;
`endif

endmodule
